tsmac_rx_fifo_unpack: RTL
=========================

// Module: tsmac_rx_fifo_unpack
// PURPOSE
//  Read-side consumer of the TSMAC RX async FIFO (10-bit words, depth 32, non-registered output).
//  Pops words while the FIFO is non-empty and unpacks each word into a byte plus flags.
//  Enforces frame boundaries and MAX_LEN truncation, and presents a sop/eop/err byte stream with valid/ready backpressure.
//  Keeps saturating frame and error statistics.
//  FIFO word format: [7:0] byte, [8] last (end of frame), [9] err (GMII rx_er seen on this byte).
// PARAMETERS
//  FIFO_DW   10    FIFO word width; fixed format above
//  MAX_LEN   1522  max bytes per frame; byte MAX_LEN without last is truncated
//  LEN_W     11    frame byte counter width; must satisfy 2**LEN_W > MAX_LEN
//  CNT_W     16    statistics counter width
// PORTS
//  rd_clk        in   1        single clock (FIFO read clock)
//  rd_rst        in   1        synchronous active-high reset
//  rd_empty      in   1        FIFO empty flag
//  rd_data       in   FIFO_DW  FIFO read data; valid 1 cycle after rd_en
//  rd_en         out  1        FIFO pop request
//  m_data        out  8        output byte
//  m_valid       out  1        output byte valid
//  m_ready       in   1        downstream accept
//  m_sop         out  1        first byte of frame
//  m_eop         out  1        last byte of frame
//  m_err         out  1        frame error; qualified by m_eop
//  frame_cnt     out  CNT_W    frames delivered (saturating)
//  err_cnt       out  CNT_W    frames delivered with m_err (saturating)
// BEHAVIOUR
//  Reset (sync, rd_rst=1 at posedge rd_clk):
//   - rd_en=0, m_valid=0, m_data/m_sop/m_eop/m_err=0, counters=0.
//   - Buffer emptied, in-flight read discarded, state=IDLE, len=0.
//   - A frame in progress at reset is abandoned; no eop is emitted for it.
//  Read issue:
//   - rd_en = !rd_empty && !rd_rst && (occ + rd_en_q) <= 2.
//   - occ is output buffer occupancy (0..4); rd_en_q is rd_en delayed 1 cycle (the read in flight).
//   - No combinational path from m_ready to rd_en.
//   - Buffer depth is 4; it never overflows. Steady-state throughput is 1 byte/cycle.
//  Capture:
//   - In the cycle where rd_en_q=1, rd_data is processed by the FSM.
//   - An entry is pushed to the buffer unless the word is dropped.
//  FSM (advances on each captured word only):
//   - IDLE: push {byte, sop=1, eop=last, err=err}; len<=1.
//     - last=1: stay IDLE (1-byte frame).
//     - else: go to FRAME.
//   - FRAME: push {byte, sop=0}; err_acc |= err; len<=len+1.
//     - last=1: push eop=1, err=err_acc|err, go to IDLE.
//     - len+1==MAX_LEN and last=0: push eop=1, err=1 (truncated), go to DISCARD.
//   - DISCARD: drop the word (no push).
//     - last=1: go to IDLE.
//   - err_acc clears on entry to IDLE.
//  Output:
//   - m_* reflect the buffer head; m_valid = (occ != 0).
//   - Pop on m_valid && m_ready. Head fields stay stable while m_valid && !m_ready.
//   - Push and pop in the same cycle: occ is unchanged; order is preserved (FIFO).
//   - Latency: rd_en -> word captured +1 cycle -> m_valid +1 cycle when the buffer was empty.
//  Statistics:
//   - frame_cnt += 1 on each popped entry with m_eop.
//   - err_cnt += 1 on each popped entry with m_eop && m_err.
//   - Both saturate at all-ones.
//  rd_empty is trusted: a read is issued only when rd_empty=0.
// TESTING
//  - 64-byte frame (bytes 0x00..0x3F, last on 0x3F), m_ready=1:
//    -> 64 bytes out in order, sop on 0x00, eop on 0x3F, err=0, frame_cnt=1.
//  - 1-byte frame {last=1, 0xA5}:
//    -> single beat with sop=eop=1, data 0xA5; FSM returns to IDLE.
//  - 1530-byte frame, MAX_LEN=1522:
//    -> 1522 bytes out, eop=1 and err=1 on byte 1522.
//    -> remaining 8 words dropped; next frame starts with sop=1; err_cnt=1.
//  - m_ready toggled 1-of-3 cycles during a 40-byte frame:
//    -> no loss, no duplicates, occ<=4.
//    -> rd_en deasserts whenever occ+rd_en_q>2.
//  - err bit set on byte 5 of a 10-byte frame:
//    -> eop beat carries err=1; frame_cnt=1, err_cnt=1.
//  - rd_rst asserted mid-frame with 3 bytes buffered:
//    -> next cycle m_valid=0, rd_en=0, counters=0.
//    -> next word after release starts a frame with sop=1.

Source files
------------

// File: rtl/tsmac_rx_fifo_unpack.sv
// tsmac_rx_fifo_unpack: pops TSMAC RX FIFO words, enforces frame boundaries and MAX_LEN,
// and presents a buffered sop/eop/err byte stream with saturating frame/error statistics.
module tsmac_rx_fifo_unpack #(
    parameter int FIFO_DW = 10,
    parameter int MAX_LEN = 1522,
    parameter int LEN_W   = 11,
    parameter int CNT_W   = 16
) (
    input  logic               rd_clk_i,
    input  logic               rd_rst_i,
    input  logic               rd_empty_i,
    input  logic [FIFO_DW-1:0] rd_data_i,
    output logic               rd_en_o,
    output logic [7:0]         m_data_o,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic               m_sop_o,
    output logic               m_eop_o,
    output logic               m_err_o,
    output logic [CNT_W-1:0]   frame_cnt_o,
    output logic [CNT_W-1:0]   err_cnt_o
);
    typedef enum logic [1:0] {IDLE, FRAME, DISCARD} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             err_acc_q, err_acc_d;
    logic             rd_en_q;
    logic [10:0]      buf_q [4];
    logic [1:0]       wr_q, rd_q;
    logic [2:0]       occ_q;
    logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;
    logic             push, pop, trunc;
    logic [10:0]      push_ent, head;
    logic [7:0]       w_byte;
    logic             w_last, w_err;

    assign w_byte = rd_data_i[7:0];
    assign w_last = rd_data_i[8];
    assign w_err  = rd_data_i[9];

    // Counting the in-flight read keeps occupancy at or below 3, so the 4-deep buffer never overflows.
    assign rd_en_o = !rd_empty_i && !rd_rst_i && (({1'b0, occ_q} + 4'(rd_en_q)) <= 4'd2);

    assign trunc = (len_q == LEN_W'(MAX_LEN - 1)) && !w_last;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        err_acc_d = err_acc_q;
        push      = 1'b0;
        push_ent  = '0;
        if (rd_en_q) begin
            case (state_q)
                IDLE: begin
                    push      = 1'b1;
                    push_ent  = {w_err, w_last, 1'b1, w_byte};
                    len_d     = LEN_W'(1);
                    err_acc_d = w_err;
                    state_d   = w_last ? IDLE : FRAME;
                end
                FRAME: begin
                    push      = 1'b1;
                    push_ent  = {w_last ? (err_acc_q | w_err) : trunc, w_last | trunc, 1'b0, w_byte};
                    len_d     = len_q + LEN_W'(1);
                    err_acc_d = err_acc_q | w_err;
                    state_d   = w_last ? IDLE : (trunc ? DISCARD : FRAME);
                end
                DISCARD: state_d = w_last ? IDLE : DISCARD;
                default: state_d = IDLE;
            endcase
        end
    end

    assign head      = buf_q[rd_q];
    assign m_valid_o = (occ_q != 3'd0);
    assign pop       = m_valid_o && m_ready_i;
    assign m_data_o  = m_valid_o ? head[7:0] : 8'd0;
    assign m_sop_o   = m_valid_o && head[8];
    assign m_eop_o   = m_valid_o && head[9];
    assign m_err_o   = m_valid_o && head[10];

    assign frame_cnt_o = frame_cnt_q;
    assign err_cnt_o   = err_cnt_q;

    always_ff @(posedge rd_clk_i) begin
        if (push)
            buf_q[wr_q] <= push_ent;
    end

    always_ff @(posedge rd_clk_i) begin
        if (rd_rst_i) begin
            state_q     <= IDLE;
            len_q       <= '0;
            err_acc_q   <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            occ_q       <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            err_acc_q <= err_acc_d;
            rd_en_q   <= rd_en_o;
            wr_q      <= wr_q + 2'(push);
            rd_q      <= rd_q + 2'(pop);
            occ_q     <= occ_q + 3'(push) - 3'(pop);
            if (pop && head[9] && !(&frame_cnt_q))
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            if (pop && head[9] && head[10] && !(&err_cnt_q))
                err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end
endmodule
